// File: rtl/ecmp_member_select.sv
// ecmp_member_select: resolves the divider's per-flow remainder to one member of an
// ECMP/LSP load-balance group and returns that member's one-hot output-port mask.
// The group member table (NUM_GROUPS x 16 entries) is register-held and programmed
// through the tbl_wr_* interface.
// Optional feature macro: ECMP_FAILOVER_EN adds port_live and the liveness-skip probe.

module ecmp_member_select #(
   parameter int NUM_GROUPS = 16,
   parameter int PORT_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_group,
   input  logic [3:0]        req_remainder,
   input  logic [3:0]        req_count,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [PORT_W-1:0] rsp_port,
   output logic [3:0]        rsp_member,
   output logic              rsp_err,
   input  logic              tbl_wr_en,
   input  logic [3:0]        tbl_wr_group,
   input  logic [3:0]        tbl_wr_member,
   input  logic [PORT_W-1:0] tbl_wr_port
`ifdef ECMP_FAILOVER_EN
   ,
   input  logic [PORT_W-1:0] port_live
`endif
);

   localparam int GW    = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
   localparam int DEPTH = NUM_GROUPS * 16;

   typedef enum logic [1:0] {IDLE, READ, CHECK, RESP} state_e;

   state_e            state_q, state_d;
   logic [GW-1:0]     group_q, group_d;
   logic [3:0]        member_q, member_d;
   logic [PORT_W-1:0] entry_q, entry_d;
   logic [PORT_W-1:0] rsp_port_q, rsp_port_d;
   logic [3:0]        rsp_member_q, rsp_member_d;
   logic              rsp_err_q, rsp_err_d;
`ifdef ECMP_FAILOVER_EN
   logic [3:0]        count_q, count_d;
   logic [3:0]        remainder_q, remainder_d;
   logic [3:0]        probe_q, probe_d;
   logic [4:0]        member_inc;
   logic              entry_live;
`endif

   logic [PORT_W-1:0] tbl_q [DEPTH];
   logic [PORT_W-1:0] tbl_d [DEPTH];
   logic [GW+3:0]     rd_idx;
   logic [GW+3:0]     wr_idx;

   // Group bits above log2(NUM_GROUPS) are dropped here.
   assign rd_idx = {group_q, member_q};
   assign wr_idx = {tbl_wr_group[GW-1:0], tbl_wr_member};

`ifdef ECMP_FAILOVER_EN
   assign member_inc = {1'b0, member_q} + 5'd1;
   assign entry_live = |(entry_q & port_live);
`endif

   assign req_ready  = (state_q == IDLE) && !reset;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_port   = rsp_port_q;
   assign rsp_member = rsp_member_q;
   assign rsp_err    = rsp_err_q;

   // Next table contents: at most one entry replaced by the register-interface write.
   always_comb begin
      tbl_d = tbl_q;
      if (tbl_wr_en) begin
         tbl_d[wr_idx] = tbl_wr_port;
      end
   end

   // Table storage; writes land at the clock edge in any FSM state.
   always_ff @(posedge clk) begin
      // NOTE: the table is explicitly cleared on reset because software expects a
      // freshly reset block to resolve every member to an empty mask.
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_q[i] <= '0;
         end
      end else begin
         tbl_q <= tbl_d;
      end
   end

   // Next-state and response logic for the IDLE/READ/CHECK/RESP sequence.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned,
      // which would otherwise infer a latch.
      state_d      = state_q;
      group_d      = group_q;
      member_d     = member_q;
      entry_d      = entry_q;
      rsp_port_d   = rsp_port_q;
      rsp_member_d = rsp_member_q;
      rsp_err_d    = rsp_err_q;
`ifdef ECMP_FAILOVER_EN
      count_d      = count_q;
      remainder_d  = remainder_q;
      probe_d      = probe_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               group_d  = req_group[GW-1:0];
               member_d = req_remainder;
`ifdef ECMP_FAILOVER_EN
               count_d     = req_count;
               remainder_d = req_remainder;
               probe_d     = 4'd0;
`endif
               if ((req_count == 4'd0) || (req_remainder >= req_count)) begin
                  state_d      = RESP;
                  rsp_err_d    = 1'b1;
                  rsp_port_d   = '0;
                  rsp_member_d = req_remainder;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            entry_d = tbl_q[rd_idx];
            state_d = CHECK;
         end
         CHECK: begin
`ifdef ECMP_FAILOVER_EN
            if (entry_live) begin
               rsp_port_d   = entry_q;
               rsp_member_d = member_q;
               rsp_err_d    = 1'b0;
               state_d      = RESP;
            end else begin
               probe_d  = probe_q + 4'd1;
               member_d = (member_inc == {1'b0, count_q}) ? 4'd0 : member_inc[3:0];
               if (probe_d == count_q) begin
                  rsp_err_d    = 1'b1;
                  rsp_port_d   = '0;
                  rsp_member_d = remainder_q;
                  state_d      = RESP;
               end else begin
                  state_d = READ;
               end
            end
`else
            rsp_port_d   = entry_q;
            rsp_member_d = member_q;
            rsp_err_d    = 1'b0;
            state_d      = RESP;
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM, request context and response registers.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, which is
      // also what gives a same-cycle READ the old table entry.
      if (reset) begin
         state_q      <= IDLE;
         group_q      <= '0;
         member_q     <= '0;
         entry_q      <= '0;
         rsp_port_q   <= '0;
         rsp_member_q <= '0;
         rsp_err_q    <= 1'b0;
`ifdef ECMP_FAILOVER_EN
         count_q      <= '0;
         remainder_q  <= '0;
         probe_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         group_q      <= group_d;
         member_q     <= member_d;
         entry_q      <= entry_d;
         rsp_port_q   <= rsp_port_d;
         rsp_member_q <= rsp_member_d;
         rsp_err_q    <= rsp_err_d;
`ifdef ECMP_FAILOVER_EN
         count_q      <= count_d;
         remainder_q  <= remainder_d;
         probe_q      <= probe_d;
`endif
      end
   end

endmodule
